// File: rtl/pixie_pkg.sv
// Shared Pixie timing constants and the DMA sequencer state encoding.
// The display back end imports the same constants so both ends agree on frame geometry.
package pixie_pkg;

    localparam int unsigned PIXELS_PER_LINE    = 112;
    localparam int unsigned LINES_PER_FRAME    = 262;
    localparam int unsigned ACTIVE_LINES       = 128;
    localparam int unsigned DISPLAY_START_LINE = 64;
    localparam int unsigned INT_LEAD_LINES     = 2;
    localparam int unsigned EF1_LEAD_LINES     = 4;

    localparam int unsigned H_W = 7;
    localparam int unsigned V_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_DONE
    } dma_state_t;

    function automatic logic line_in_range(input logic [V_W-1:0] v,
                                           input int unsigned lo,
                                           input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/pixie_line_timer.sv
// Horizontal/vertical pixel counters for CDP1861-style timing.
// line_wrap is high during the last clock of every line.
module pixie_line_timer
    import pixie_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           line_wrap
);

    assign line_wrap = (h == H_W'(PIXELS_PER_LINE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (line_wrap) begin
            h <= '0;
            v <= (v == V_W'(LINES_PER_FRAME - 1)) ? '0 : v + V_W'(1);
        end else begin
            h <= h + H_W'(1);
        end
    end

endmodule

// File: rtl/pixie_dma_sequencer.sv
// Pixie front end: fetches 8 DMA-out bytes per active line into the framebuffer
// and generates the line-based interrupt and EF1 flag.
module pixie_dma_sequencer
    import pixie_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_on,
    input  logic       disp_off,
    output logic       dma_req,
    input  logic       dma_ack,
    input  logic [7:0] dma_data,
    output logic       int_req,
    output logic       ef1,
    output logic       fb_we,
    output logic [9:0] fb_waddr,
    output logic [7:0] fb_wdata,
    output logic       display_enabled,
    output logic       dma_late
);

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           line_wrap;

    pixie_line_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .h         (h),
        .v         (v),
        .line_wrap (line_wrap)
    );

    logic           enable;
    logic           pend_valid;
    logic           pend_on;
    logic           req_valid_next;
    logic           req_on_next;
    logic           apply_on;
    logic           active_line;
    logic           int_next;
    logic           ef1_next;
    logic [V_W-1:0] k_full;
    logic [6:0]     k;
    logic [2:0]     b;
    dma_state_t     state;

    // A strobe in the wrap cycle itself is folded into the request applied at that edge.
    always_comb begin
        req_valid_next = pend_valid | disp_on | disp_off;
        req_on_next    = (disp_on | disp_off) ? (disp_on & ~disp_off) : pend_on;
        apply_on       = line_wrap & req_valid_next & req_on_next;
        active_line    = enable
                       && (v >= V_W'(DISPLAY_START_LINE))
                       && (v <  V_W'(DISPLAY_START_LINE + ACTIVE_LINES));
        k_full         = v - V_W'(DISPLAY_START_LINE);
        k              = k_full[6:0];
        int_next       = enable && line_in_range(v, DISPLAY_START_LINE - INT_LEAD_LINES,
                                                    DISPLAY_START_LINE - 1);
        ef1_next       = enable
                       && (line_in_range(v, DISPLAY_START_LINE - EF1_LEAD_LINES,
                                            DISPLAY_START_LINE - 1)
                        || line_in_range(v, DISPLAY_START_LINE + ACTIVE_LINES - EF1_LEAD_LINES,
                                            DISPLAY_START_LINE + ACTIVE_LINES - 1));
    end

    assign display_enabled = enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable     <= 1'b0;
            pend_valid <= 1'b0;
            pend_on    <= 1'b0;
            int_req    <= 1'b0;
            ef1        <= 1'b0;
        end else begin
            int_req <= int_next;
            ef1     <= ef1_next;
            if (line_wrap) begin
                if (req_valid_next) begin
                    enable <= req_on_next;
                end
                pend_valid <= 1'b0;
                pend_on    <= 1'b0;
            end else begin
                pend_valid <= req_valid_next;
                pend_on    <= req_on_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            b        <= '0;
            dma_req  <= 1'b0;
            fb_we    <= 1'b0;
            fb_waddr <= '0;
            fb_wdata <= '0;
            dma_late <= 1'b0;
        end else begin
            fb_we    <= 1'b0;
            fb_waddr <= '0;
            case (state)
                ST_IDLE: begin
                    if (h == '0 && active_line) begin
                        b       <= '0;
                        dma_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The line deadline beats a same-cycle ack; that byte stays stale.
                    if (line_wrap) begin
                        dma_req  <= 1'b0;
                        dma_late <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (dma_ack) begin
                        fb_wdata <= dma_data;
                        fb_we    <= 1'b1;
                        fb_waddr <= {k, b};
                        dma_req  <= 1'b0;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (b == 3'd7) begin
                        state <= line_wrap ? ST_IDLE : ST_DONE;
                    end else if (line_wrap) begin
                        dma_late <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        b       <= b + 3'd1;
                        dma_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (line_wrap) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (apply_on) begin
                dma_late <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pixie_dma_sequencer.md
Name: pixie_dma_sequencer

Overview:
- Front-end controller that fills the Pixie framebuffer consumed by the display back end.
- Runs its own CDP1861-style line/frame timing. Raises the CPU interrupt and EF1 flag at fixed lines.
- During active lines, issues 8 DMA-out byte requests per line to the CPU and writes the returned bytes into the 1 KiB framebuffer (8 bytes × 128 lines).
- Controlled by display-on/off strobes decoded from CPU I/O (INP 1 / OUT 1).

Parameters:
- PIXELS_PER_LINE, 112, clocks per line
- LINES_PER_FRAME, 262, lines per frame
- ACTIVE_LINES, 128, lines fetched per frame
- DISPLAY_START_LINE, 64, first fetched line
- INT_LEAD_LINES, 2, lines of int_req before DISPLAY_START_LINE
- EF1_LEAD_LINES, 4, EF1 lines before start and before end of the active window

Ports:
- clk  in  1  pixel clock, same as back end
- reset  in  1  asynchronous, active-high
- disp_on  in  1  one-cycle strobe: enable display (INP 1)
- disp_off  in  1  one-cycle strobe: disable display (OUT 1)
- dma_req  out  1  request one DMA-out byte from CPU
- dma_ack  in  1  CPU grant; dma_data valid this cycle
- dma_data  in  8  byte from CPU
- int_req  out  1  CPU interrupt request, active-high
- ef1  out  1  EF1 flag, active-high
- fb_we  out  1  framebuffer write strobe
- fb_waddr  out  10  {line[6:0], byte[2:0]}
- fb_wdata  out  8  write data
- display_enabled  out  1  current enable state
- dma_late  out  1  sticky: a line ended with fewer than 8 bytes fetched

Behaviour:
- Reset (async): h=0, v=0, all outputs 0, state IDLE, enable=0, pending enable request cleared.
- Counters:
  - h counts 0..PIXELS_PER_LINE-1, then wraps to 0.
  - v increments when h wraps; v wraps 261→0.
- Enable control:
  - disp_on/disp_off latch a pending request; it is applied when h wraps (line boundary).
  - disp_off and disp_on in the same cycle: disp_off wins.
  - Applying disp_on clears dma_late.
  - display_enabled reflects the applied state.
- Active line: enable=1 and DISPLAY_START_LINE ≤ v < DISPLAY_START_LINE+ACTIVE_LINES. Fetch line index k = v - DISPLAY_START_LINE.
- int_req = enable && v in [DISPLAY_START_LINE-INT_LEAD_LINES, DISPLAY_START_LINE-1].
- ef1 = enable && v in [DISPLAY_START_LINE-EF1_LEAD_LINES, DISPLAY_START_LINE-1] or [DISPLAY_START_LINE+ACTIVE_LINES-EF1_LEAD_LINES, DISPLAY_START_LINE+ACTIVE_LINES-1].
- int_req and ef1 are registered: they update the cycle after v changes.
- FSM states:
  - IDLE: at h==0 of an active line, byte b=0, go to REQ.
  - REQ: dma_req=1. On dma_ack, register dma_data into fb_wdata and go to WRITE.
  - WRITE: fb_we=1 for exactly one cycle, addr {k,b}, dma_req=0. If b==7 go to DONE, else b++ and go to REQ.
  - DONE: dma_req=0. At h wrap, go to IDLE.
- Timing:
  - Minimum 2 clocks per byte. fb_we asserts 1 cycle after dma_ack.
  - dma_ack while dma_req=0 is ignored.
  - dma_req stays high until acked; there is no timeout within the line.
- Line deadline: if h==PIXELS_PER_LINE-1 and state is REQ or WRITE:
  - Any WRITE in that cycle completes.
  - Remaining bytes of the line are not fetched; dma_req drops the next cycle.
  - dma_late is set; the FSM returns to IDLE.
  - Stale framebuffer contents remain for those bytes.
- Disable takes effect only at a line boundary, so a burst in progress always completes or hits the deadline.
- Enable=0: no requests, no writes, int_req=ef1=0. Counters keep running.
- Address width: k is truncated to 7 bits; b is 3 bits. fb_waddr stays 0 except during WRITE.

Decomposition:
- Package pixie_pkg: timing constants (112, 262, 128, 64, lead lines) and the FSM state enum. The back end uses the same constants.
- Sub-module pixie_line_timer: h/v counters plus the line-wrap pulse, reusable by the back end.

Test Plan:
- Reset mid-burst: assert reset while dma_req=1 at v=70, b=3 → all outputs 0 immediately; after release, no request until enabled and the next active line.
- disp_on, CPU acks 1 cycle after each request → int_req high for lines 62–63; ef1 high for lines 60–63 and 188–191; each active line gives 8 fb_we pulses; line 64 writes addr 0..7, line 191 writes addr 1016..1023 with the acked data.
- Slow CPU acking every 20 clocks → only 5 bytes written per line (fb_we at b=0..4); dma_late=1 after line 64; the next disp_on clears it.
- disp_off at h=30 of line 100 → line 100 completes all 8 bytes; no dma_req on line 101; int_req/ef1 stay 0 in the next frame.
- disp_on and disp_off in the same cycle → display_enabled stays 0.
- dma_ack pulsed while dma_req=0 during the DONE state → no fb_we, b unchanged.
